// File: rtl/vga_text_pkg.sv
// Shared constants and state encoding for the VGA text-memory arbiter.
//   TXT_COLS/TXT_ROWS     : text grid dimensions (defaults)
//   TXT_CHAR_W/TXT_CHAR_H : character cell size in pixels (powers of 2)
//   TEXT_CELLS            : number of addressable text cells
//   TXT_ADDR_W/TXT_DATA_W : text RAM address / data widths
//   arb_state_e           : arbiter FSM state encoding
package vga_text_pkg;

    localparam int TXT_COLS   = 80;
    localparam int TXT_ROWS   = 30;
    localparam int TXT_CHAR_W = 8;
    localparam int TXT_CHAR_H = 16;
    localparam int TEXT_CELLS = TXT_COLS * TXT_ROWS;
    localparam int TXT_ADDR_W = 12;
    localparam int TXT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAIT    = 2'd2,
        HOST_WR = 2'd3
    } arb_state_e;

endpackage

// File: rtl/text_cell_addr.sv
// Combinational pixel-to-text-cell address translation.
//   px, py    : current pixel column / row
//   cell_addr : (py / CHAR_H) * COLS + px / CHAR_W, truncated to ADDR_W
// Divisions are shifts (cell sizes are powers of 2) and the row scaling is a
// multiply by a constant, which reduces to shift/add logic.
module text_cell_addr
    import vga_text_pkg::*;
#(
    parameter int COLS   = TXT_COLS,
    parameter int CHAR_W = TXT_CHAR_W,
    parameter int CHAR_H = TXT_CHAR_H,
    parameter int ADDR_W = TXT_ADDR_W
) (
    input  logic [9:0]        px,
    input  logic [9:0]        py,
    output logic [ADDR_W-1:0] cell_addr
);

    localparam int CW_SH = $clog2(CHAR_W);
    localparam int CH_SH = $clog2(CHAR_H);

    logic [9:0] col;
    logic [9:0] row;

    assign col       = px >> CW_SH;
    assign row       = py >> CH_SH;
    assign cell_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

endmodule

// File: rtl/vga_text_mem_arbiter.sv
// Arbiter for the single-port text RAM behind the VGA text renderer.
// The display fetch path (one read per character cell) has priority over a
// host write port using a level req / one-cycle ack handshake.
//   clk, reset (sync, active-low)
//   pix_tick, video_on, px, py      : pixel timing; generate fetch triggers
//   host_req/addr/data, host_ack/err: host write handshake
//   mem_addr/we/wdata, mem_rdata    : synchronous RAM, 1-cycle read latency
//   char_code, char_valid           : fetched code and its update pulse
//   fetch_ovf                       : sticky, a fetch trigger was dropped
//   state_dbg                       : current FSM state
// Handshake: host_req is a level held with stable addr/data until host_ack
// pulses for one cycle; a host_req still high in the cycle after host_ack is
// treated as a new request.
module vga_text_mem_arbiter
    import vga_text_pkg::*;
#(
    parameter int COLS   = TXT_COLS,
    parameter int ROWS   = TXT_ROWS,
    parameter int CHAR_W = TXT_CHAR_W,
    parameter int CHAR_H = TXT_CHAR_H,
    parameter int ADDR_W = TXT_ADDR_W,
    parameter int DATA_W = TXT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_tick,
    input  logic              video_on,
    input  logic [9:0]        px,
    input  logic [9:0]        py,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ack,
    output logic              host_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] char_code,
    output logic              char_valid,
    output logic              fetch_ovf,
    output logic [1:0]        state_dbg
);

    localparam int CELLS = COLS * ROWS;
    localparam int CW_SH = $clog2(CHAR_W);

    logic              trigger;
    logic [ADDR_W-1:0] cell_addr;
    logic              host_in_range;

    arb_state_e        state_q,      state_d;
    logic              pend_q,       pend_d;
    logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              mem_we_q,     mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              host_ack_q,   host_ack_d;
    logic              host_err_q,   host_err_d;
    logic [DATA_W-1:0] char_code_q,  char_code_d;
    logic              char_valid_q, char_valid_d;
    logic              fetch_ovf_q,  fetch_ovf_d;

    text_cell_addr #(
        .COLS   (COLS),
        .CHAR_W (CHAR_W),
        .CHAR_H (CHAR_H),
        .ADDR_W (ADDR_W)
    ) u_cell_addr (
        .px        (px),
        .py        (py),
        .cell_addr (cell_addr)
    );

    // One fetch at the first pixel of every character cell.
    assign trigger       = pix_tick && video_on && (px[CW_SH-1:0] == '0);
    assign host_in_range = (host_addr < ADDR_W'(CELLS));

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        fetch_addr_d = fetch_addr_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        host_ack_d   = 1'b0;
        host_err_d   = 1'b0;
        char_code_d  = char_code_q;
        char_valid_d = 1'b0;
        fetch_ovf_d  = fetch_ovf_q;

        // A trigger that arrives while the RAM is busy is parked in the
        // single pending slot; a second one while the slot is full is lost.
        if (state_q != IDLE && trigger) begin
            if (pend_q) begin
                fetch_ovf_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_addr_d = cell_addr;
            end
        end

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    // Serve the older parked fetch first; a coincident new
                    // trigger takes over the freed slot.
                    fetch_addr_d = pend_addr_q;
                    mem_addr_d   = pend_addr_q;
                    pend_d       = trigger;
                    if (trigger) begin
                        pend_addr_d = cell_addr;
                    end
                    state_d = FETCH;
                end else if (trigger) begin
                    fetch_addr_d = cell_addr;
                    mem_addr_d   = cell_addr;
                    state_d      = FETCH;
                end else if (host_req) begin
                    // Write-side outputs are registered on entry so they
                    // are visible during the HOST_WR cycle.
                    host_ack_d = 1'b1;
                    if (host_in_range) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = host_addr;
                        mem_wdata_d = host_data;
                    end else begin
                        host_err_d = 1'b1;
                    end
                    state_d = HOST_WR;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                char_code_d  = mem_rdata;
                char_valid_d = 1'b1;
                state_d      = IDLE;
            end
            HOST_WR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            fetch_addr_q <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            host_ack_q   <= 1'b0;
            host_err_q   <= 1'b0;
            char_code_q  <= '0;
            char_valid_q <= 1'b0;
            fetch_ovf_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            host_ack_q   <= host_ack_d;
            host_err_q   <= host_err_d;
            char_code_q  <= char_code_d;
            char_valid_q <= char_valid_d;
            fetch_ovf_q  <= fetch_ovf_d;
        end
    end

    assign host_ack   = host_ack_q;
    assign host_err   = host_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign char_code  = char_code_q;
    assign char_valid = char_valid_q;
    assign fetch_ovf  = fetch_ovf_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_vga_text_mem_arbiter.sv
// Directed bench for vga_text_mem_arbiter with a synchronous RAM model and
// scoreboards for fetched character codes and RAM writes.
module tb_vga_text_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_tick, video_on;
  logic [9:0]  px, py;
  logic        host_req;
  logic [11:0] host_addr;
  logic [7:0]  host_data;
  logic        host_ack, host_err;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  char_code;
  logic        char_valid;
  logic        fetch_ovf;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram   [0:4095];
  logic [7:0]  model [0:4095];
  logic [7:0]  exp_char_q[$];
  logic [19:0] exp_wr_q[$];

  // clock / reset
  always #5 clk = ~clk;

  vga_text_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .pix_tick   (pix_tick),
    .video_on   (video_on),
    .px         (px),
    .py         (py),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .host_ack   (host_ack),
    .host_err   (host_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .char_code  (char_code),
    .char_valid (char_valid),
    .fetch_ovf  (fetch_ovf),
    .state_dbg  (state_dbg)
  );

  // synchronous single-port RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver helpers: set inputs and record what the DUT should produce
  task automatic drive_trigger(input logic [9:0] x, input logic [9:0] y);
    int a;
    pix_tick = 1'b1;
    video_on = 1'b1;
    px = x;
    py = y;
    a = (int'(y) / 16) * 80 + int'(x) / 8;
    exp_char_q.push_back(model[a]);
  endtask

  task automatic drive_host(input logic [11:0] a, input logic [7:0] d);
    host_req  = 1'b1;
    host_addr = a;
    host_data = d;
    if (int'(a) < 2400) begin
      exp_wr_q.push_back({a, d});
      model[a] = d;
    end
  endtask

  // scoreboard: compare DUT outputs against the expected queues
  always @(negedge clk) begin
    logic [7:0]  ec;
    logic [19:0] ew;
    if (char_valid === 1'b1) begin
      checks++;
      assert (exp_char_q.size() != 0) else begin
        errors++;
        $error("FAIL char_unexpected: got 0x%0h expected none", char_code);
      end
      if (exp_char_q.size() != 0) begin
        ec = exp_char_q.pop_front();
        checks++;
        assert (char_code === ec) else begin
          errors++;
          $error("FAIL sb_char: got 0x%0h expected 0x%0h", char_code, ec);
        end
      end
    end
    if (mem_we === 1'b1) begin
      checks++;
      assert (exp_wr_q.size() != 0) else begin
        errors++;
        $error("FAIL wr_unexpected: got 0x%0h expected none", {mem_addr, mem_wdata});
      end
      if (exp_wr_q.size() != 0) begin
        ew = exp_wr_q.pop_front();
        checks++;
        assert ({mem_addr, mem_wdata} === ew) else begin
          errors++;
          $error("FAIL sb_write: got 0x%0h expected 0x%0h", {mem_addr, mem_wdata}, ew);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]   = 8'(i) ^ 8'hC3;
      model[i] = 8'(i) ^ 8'hC3;
    end
    ram[12'h051]   = 8'h41;
    model[12'h051] = 8'h41;

    // reset held with host_req and trigger active
    reset     = 1'b0;
    pix_tick  = 1'b1;
    video_on  = 1'b1;
    px        = 10'd0;
    py        = 10'd0;
    host_req  = 1'b1;
    host_addr = 12'h010;
    host_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ack", host_ack, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_valid", char_valid, 0);
      chk("rst_code", char_code, 0);
      chk("rst_ovf", fetch_ovf, 0);
      chk("rst_err", host_err, 0);
      chk("rst_state", state_dbg, 0);
    end
    reset    = 1'b1;
    pix_tick = 1'b0;
    drive_host(12'h010, 8'h77);
    step();
    chk("rel_ack", host_ack, 1);
    chk("rel_we", mem_we, 1);
    chk("rel_addr", mem_addr, 12'h010);
    host_req = 1'b0;
    step();
    chk("rel_ack_off", host_ack, 0);
    chk("rel_we_off", mem_we, 0);
    step();

    // basic fetch: cell (1,1) -> 0x051
    drive_trigger(10'h008, 10'h010);
    step();
    pix_tick = 1'b0;
    chk("f_state1", state_dbg, 1);
    chk("f_addr", mem_addr, 12'h051);
    chk("f_we", mem_we, 0);
    chk("f_valid1", char_valid, 0);
    step();
    chk("f_state2", state_dbg, 2);
    chk("f_valid2", char_valid, 0);
    step();
    chk("f_valid3", char_valid, 1);
    chk("f_code3", char_code, 8'h41);
    step();
    chk("f_valid4", char_valid, 0);
    chk("f_hold", char_code, 8'h41);

    // non-trigger pixels: unaligned px and blanking
    pix_tick = 1'b1;
    px = 10'd9;
    step();
    chk("nt_unaligned", state_dbg, 0);
    px = 10'd16;
    video_on = 1'b0;
    step();
    chk("nt_blank", state_dbg, 0);
    pix_tick = 1'b0;
    video_on = 1'b1;
    step();

    // host write from idle, then read it back through the fetch path
    drive_host(12'h12C, 8'h5A);
    step();
    chk("hw_ack", host_ack, 1);
    chk("hw_we", mem_we, 1);
    chk("hw_addr", mem_addr, 12'h12C);
    chk("hw_data", mem_wdata, 8'h5A);
    chk("hw_err", host_err, 0);
    host_req = 1'b0;
    step();
    chk("hw_ack_off", host_ack, 0);
    chk("hw_we_off", mem_we, 0);
    step();
    chk("hw_no_dup", mem_we, 0);
    drive_trigger(10'd480, 10'd48);
    step();
    pix_tick = 1'b0;
    chk("rb_addr", mem_addr, 12'h12C);
    step();
    step();
    chk("rb_code", char_code, 8'h5A);
    step();

    // collision: fetch beats host
    drive_trigger(10'd0, 10'd0);
    drive_host(12'h010, 8'h33);
    step();
    pix_tick = 1'b0;
    chk("c_state1", state_dbg, 1);
    chk("c_addr1", mem_addr, 12'h000);
    chk("c_ack1", host_ack, 0);
    step();
    chk("c_state2", state_dbg, 2);
    chk("c_ack2", host_ack, 0);
    step();
    chk("c_valid3", char_valid, 1);
    chk("c_ack3", host_ack, 0);
    step();
    chk("c_ack4", host_ack, 1);
    chk("c_we4", mem_we, 1);
    chk("c_addr4", mem_addr, 12'h010);
    host_req = 1'b0;
    step();
    step();

    // pending: trigger during HOST_WR is served afterwards
    drive_host(12'h020, 8'h44);
    step();
    chk("p_ack", host_ack, 1);
    chk("p_state", state_dbg, 3);
    host_req = 1'b0;
    drive_trigger(10'd16, 10'd32);
    step();
    pix_tick = 1'b0;
    chk("p_idle", state_dbg, 0);
    chk("p_we_off", mem_we, 0);
    step();
    chk("p_fetch", state_dbg, 1);
    chk("p_addr", mem_addr, 12'h0A2);
    step();
    step();
    chk("p_valid", char_valid, 1);
    chk("p_ovf", fetch_ovf, 0);
    step();

    // overflow: triggers in FETCH (parked) and WAIT (dropped)
    drive_trigger(10'd24, 10'd32);
    step();
    chk("o_state1", state_dbg, 1);
    chk("o_addr1", mem_addr, 12'h0A3);
    chk("o_ovf1", fetch_ovf, 0);
    drive_trigger(10'd32, 10'd32);
    step();
    chk("o_state2", state_dbg, 2);
    chk("o_ovf2", fetch_ovf, 0);
    px = 10'd40;
    step();
    pix_tick = 1'b0;
    chk("o_ovf3", fetch_ovf, 1);
    chk("o_valid3", char_valid, 1);
    chk("o_state3", state_dbg, 0);
    step();
    chk("o_state4", state_dbg, 1);
    chk("o_addr4", mem_addr, 12'h0A4);
    step();
    step();
    chk("o_valid6", char_valid, 1);
    for (int i = 0; i < 4; i++) step();
    chk("o_sticky", fetch_ovf, 1);

    // address range boundary
    drive_host(12'h960, 8'hEE);
    step();
    chk("r_ack_hi", host_ack, 1);
    chk("r_err_hi", host_err, 1);
    chk("r_we_hi", mem_we, 0);
    host_req = 1'b0;
    step();
    chk("r_err_off", host_err, 0);
    step();
    drive_host(12'h95F, 8'h99);
    step();
    chk("r_ack_lo", host_ack, 1);
    chk("r_err_lo", host_err, 0);
    chk("r_we_lo", mem_we, 1);
    chk("r_addr_lo", mem_addr, 12'h95F);
    host_req = 1'b0;
    step();
    step();

    // reset clears sticky overflow
    reset = 1'b0;
    step();
    chk("r2_ovf", fetch_ovf, 0);
    chk("r2_state", state_dbg, 0);
    chk("r2_addr", mem_addr, 0);
    reset = 1'b1;
    step();

    chk("sb_char_empty", exp_char_q.size(), 0);
    chk("sb_wr_empty", exp_wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
